// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light request arbiter:
// light output encoding and the arbiter phase-tracking state.
package tl_pkg;

  // Light car-output encoding (LA / LB)
  localparam logic [1:0] RED          = 2'b00;
  localparam logic [1:0] YELLOW       = 2'b01;
  localparam logic [1:0] GREEN        = 2'b10;
  localparam logic [1:0] BLINKING_RED = 2'b11;

  // Arbiter view of which street currently owns green
  typedef enum logic [2:0] {
    SYNC = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    XFER = 3'd3,
    FLT  = 3'd4
  } arb_state_e;

  function automatic logic is_green(input logic [1:0] light);
    return light == GREEN;
  endfunction

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchroniser followed by a debouncer: the output level only
// follows the synchronised input after it has disagreed with the current
// level for DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts.
module tl_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYC - 1);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic [3:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; flip the level on the last one
  always_comb begin
    level_d = level_q;
    cnt_d   = 4'd0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Synchroniser and debounce state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/traffic_request_arbiter.sv
// Request scheduler for the two-street traffic light. Debounces the field
// detectors/buttons, latches per-phase requests and drives the SA/SB
// switch requests with a bounded green extension.
// Optional feature: define TL_ARB_EMERGENCY_EN to add EMG_A/EMG_B
// emergency-vehicle inputs (synchronised, not debounced).
module traffic_request_arbiter
  import tl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int MAX_EXT      = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CAR_A,
  input  logic       CAR_B,
  input  logic       PED_A,
  input  logic       PED_B,
`ifdef TL_ARB_EMERGENCY_EN
  input  logic       EMG_A,
  input  logic       EMG_B,
`endif
  input  logic [1:0] LA,
  input  logic [1:0] LB,
  output logic       SA,
  output logic       SB,
  output logic       WAIT_A,
  output logic       WAIT_B,
  output logic       FAULT
);

  localparam logic [7:0] EXT_MAX = 8'(MAX_EXT);

  // Input conditioning: bit 0 CAR_A, 1 CAR_B, 2 PED_A, 3 PED_B
  logic [3:0] raw_in;
  logic [3:0] db_lvl;

  assign raw_in = {PED_B, PED_A, CAR_B, CAR_A};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
      tl_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_db (
        .CLK    (CLK),
        .RST    (RST),
        .raw_i  (raw_in[gi]),
        .level_o(db_lvl[gi])
      );
    end
  endgenerate

  logic car_a_db, car_b_db, ped_a_db, ped_b_db;
  assign car_a_db = db_lvl[0];
  assign car_b_db = db_lvl[1];
  assign ped_a_db = db_lvl[2];
  assign ped_b_db = db_lvl[3];

  logic ped_a_prev_q, ped_b_prev_q;
  logic ped_a_rise, ped_b_rise;
  assign ped_a_rise = ped_a_db & ~ped_a_prev_q;
  assign ped_b_rise = ped_b_db & ~ped_b_prev_q;

  // Emergency overrides: force a ped-flagged request and block the other side
  logic emg_set_a, emg_set_b;
  logic block_sa, block_sb;

`ifdef TL_ARB_EMERGENCY_EN
  logic emg_a_s1_q, emg_a_s2_q, emg_b_s1_q, emg_b_s2_q;

  // Two-flop synchronisers for the emergency inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      emg_a_s1_q <= 1'b0;
      emg_a_s2_q <= 1'b0;
      emg_b_s1_q <= 1'b0;
      emg_b_s2_q <= 1'b0;
    end else begin
      emg_a_s1_q <= EMG_A;
      emg_a_s2_q <= emg_a_s1_q;
      emg_b_s1_q <= EMG_B;
      emg_b_s2_q <= emg_b_s1_q;
    end
  end

  // EMG_A takes priority when both emergencies are active
  assign emg_set_a = emg_a_s2_q;
  assign emg_set_b = emg_b_s2_q & ~emg_a_s2_q;
  assign block_sb  = emg_set_a;
  assign block_sa  = emg_set_b;
`else
  assign emg_set_a = 1'b0;
  assign emg_set_b = 1'b0;
  assign block_sa  = 1'b0;
  assign block_sb  = 1'b0;
`endif

  logic la_green, lb_green;
  assign la_green = is_green(LA);
  assign lb_green = is_green(LB);

  // Request latches (phase A serves PED_B, phase B serves PED_A)
  logic req_a_q, req_a_d, req_b_q, req_b_d;
  logic ped_a_q, ped_a_d, ped_b_q, ped_b_d;
  logic set_a, set_b, pset_a, pset_b;

  assign pset_a = ped_b_rise | emg_set_a;
  assign pset_b = ped_a_rise | emg_set_b;
  assign set_a  = car_a_db | pset_a;
  assign set_b  = car_b_db | pset_b;

  // Set/clear of requests; the served street being green clears and wins
  always_comb begin
    req_a_d = (req_a_q | set_a)  & ~la_green;
    ped_a_d = (ped_a_q | pset_a) & ~la_green;
    req_b_d = (req_b_q | set_b)  & ~lb_green;
    ped_b_d = (ped_b_q | pset_b) & ~lb_green;
  end

  arb_state_e state_q, state_d;
  logic [7:0] ext_q, ext_d;
  logic       sa_q, sa_d, sb_q, sb_d, fault_q, fault_d;
  logic       ext_full;

  // Counter reflects the current phase only when the phase is not changing
  assign ext_full = (ext_q == EXT_MAX) && (state_q == state_d);

  // Phase decode, extension counter and switch requests
  always_comb begin
    state_d = state_q;
    if (state_q == FLT || (la_green && lb_green)) begin
      state_d = FLT;
    end else if (la_green) begin
      state_d = PH_A;
    end else if (lb_green) begin
      state_d = PH_B;
    end else if (state_q != SYNC) begin
      state_d = XFER;
    end

    ext_d = ext_q;
    if (state_d != state_q) begin
      ext_d = 8'd0;
    end else if ((state_q == PH_A && req_b_q) || (state_q == PH_B && req_a_q)) begin
      if (ext_q != EXT_MAX) ext_d = ext_q + 8'd1;
    end

    sb_d = (state_d == PH_A) &&
           (sb_q || (req_b_q && !block_sb && (ped_b_q || !car_a_db || ext_full)));
    sa_d = (state_d == PH_B) &&
           (sa_q || (req_a_q && !block_sa && (ped_a_q || !car_b_db || ext_full)));
    fault_d = (state_d == FLT);
  end

  // Arbiter state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= SYNC;
      ext_q        <= 8'd0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      fault_q      <= 1'b0;
      req_a_q      <= 1'b0;
      req_b_q      <= 1'b0;
      ped_a_q      <= 1'b0;
      ped_b_q      <= 1'b0;
      ped_a_prev_q <= 1'b0;
      ped_b_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ext_q        <= ext_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      fault_q      <= fault_d;
      req_a_q      <= req_a_d;
      req_b_q      <= req_b_d;
      ped_a_q      <= ped_a_d;
      ped_b_q      <= ped_b_d;
      ped_a_prev_q <= ped_a_db;
      ped_b_prev_q <= ped_b_db;
    end
  end

  assign SA     = sa_q;
  assign SB     = sb_q;
  assign WAIT_A = req_a_q;
  assign WAIT_B = req_b_q;
  assign FAULT  = fault_q;

endmodule

// File: tb/tb_traffic_request_arbiter.sv
// Scoreboard bench for traffic_request_arbiter: stimulus pushes expected
// output values tagged with the cycle they must appear; a monitor on the
// falling edge pops and compares them.
module tb_traffic_request_arbiter;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;

  // Output vector bit order: {SA, SB, WAIT_A, WAIT_B, FAULT}
  localparam logic [4:0] M_SA  = 5'b10000;
  localparam logic [4:0] M_SB  = 5'b01000;
  localparam logic [4:0] M_WA  = 5'b00100;
  localparam logic [4:0] M_WB  = 5'b00010;
  localparam logic [4:0] M_F   = 5'b00001;
  localparam logic [4:0] M_ALL = 5'b11111;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CAR_A = 1'b0, CAR_B = 1'b0, PED_A = 1'b0, PED_B = 1'b0;
`ifdef TL_ARB_EMERGENCY_EN
  logic       EMG_A = 1'b0, EMG_B = 1'b0;
`endif
  logic [1:0] LA = L_RED, LB = L_RED;
  logic       SA, SB, WAIT_A, WAIT_B, FAULT;

  traffic_request_arbiter #(
    .DEBOUNCE_CYC(4),
    .MAX_EXT     (8)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .CAR_A (CAR_A),
    .CAR_B (CAR_B),
    .PED_A (PED_A),
    .PED_B (PED_B),
`ifdef TL_ARB_EMERGENCY_EN
    .EMG_A (EMG_A),
    .EMG_B (EMG_B),
`endif
    .LA    (LA),
    .LB    (LB),
    .SA    (SA),
    .SB    (SB),
    .WAIT_A(WAIT_A),
    .WAIT_B(WAIT_B),
    .FAULT (FAULT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] mask;
    logic [4:0] val;
  } exp_t;

  exp_t exp_fifo[$];
  int   checks = 0;
  int   passed = 0;

  function automatic void expect_at(input int c, input string nm,
                                    input logic [4:0] m, input logic [4:0] v);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.mask = m;
    e.val  = v;
    exp_fifo.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: compare every expectation due in the current cycle
  always @(negedge CLK) begin
    logic [4:0] act;
    act = {SA, SB, WAIT_A, WAIT_B, FAULT};
    for (int i = exp_fifo.size() - 1; i >= 0; i--) begin
      if (exp_fifo[i].cyc == cyc) begin
        checks++;
        if ((act & exp_fifo[i].mask) == (exp_fifo[i].val & exp_fifo[i].mask)) begin
          passed++;
          $display("cyc %0d %s: ok {SA,SB,WA,WB,F}=%b", cyc, exp_fifo[i].name, act);
        end else begin
          $display("FAIL cyc %0d %s: got {SA,SB,WA,WB,F}=%b want %b (mask %b)",
                   cyc, exp_fifo[i].name, act, exp_fifo[i].val, exp_fifo[i].mask);
        end
        exp_fifo.delete(i);
      end else if (exp_fifo[i].cyc < cyc) begin
        checks++;
        $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)",
                 exp_fifo[i].name, exp_fifo[i].cyc, cyc);
        exp_fifo.delete(i);
      end
    end
  end

  int base;

  initial begin
    // Reset state
    LA = L_GREEN;
    LB = L_RED;
    expect_at(2, "reset_outputs", M_ALL, 5'b00000);
    expect_at(3, "reset_outputs_hold", M_ALL, 5'b00000);
    step(4);
    RST = 1'b0;
    step(3);

    // Ped button served by phase B, gap present: WAIT_B at 7, SB at 8
    base = cyc;
    PED_A = 1'b1;
    expect_at(base + 6, "ped_waitb_not_yet", M_WB | M_SB, 5'b00000);
    expect_at(base + 7, "ped_waitb_set", M_WB | M_SB, 5'b00010);
    expect_at(base + 8, "ped_sb_set", M_ALL, 5'b01010);
    step(10);
    PED_A = 1'b0;
    step(2);
    base = cyc;
    LA = L_YELLOW;
    expect_at(base + 1, "sb_drop_on_yellow", M_SB | M_WB, 5'b00010);
    step(2);
    base = cyc;
    LA = L_RED;
    LB = L_GREEN;
    expect_at(base + 1, "waitb_clear_on_lb_green", M_WB | M_SA | M_SB, 5'b00000);
    step(3);

    // Extension: CAR_A busy, CAR_B arrives -> reqB at 7, SB at 16
    LA = L_GREEN;
    LB = L_RED;
    step(2);
    CAR_A = 1'b1;
    step(10);
    base = cyc;
    CAR_B = 1'b1;
    expect_at(base + 6, "ext_reqb_not_yet", M_WB, 5'b00000);
    expect_at(base + 7, "ext_reqb_set", M_WB | M_SB, 5'b00010);
    expect_at(base + 15, "ext_sb_deferred", M_SB, 5'b00000);
    expect_at(base + 16, "ext_sb_set", M_ALL, 5'b01010);
    step(17);
    base = cyc;
    LA = L_YELLOW;
    expect_at(base + 1, "ext_xfer_sb_drop_reqa", M_SB | M_WA, 5'b00100);
    step(2);
    // Mirror: phase B with CAR_B busy, pending reqA -> SA after full extension
    base = cyc;
    LA = L_RED;
    LB = L_GREEN;
    expect_at(base + 1, "phb_waitb_clear", M_WB | M_SA, 5'b00000);
    expect_at(base + 9, "phb_sa_deferred", M_SA, 5'b00000);
    expect_at(base + 10, "phb_sa_set", M_SA | M_WA, 5'b10100);
    step(11);

    // Glitch shorter than the debounce window is ignored
    CAR_A = 1'b0;
    CAR_B = 1'b0;
    step(10);
    LA = L_GREEN;
    LB = L_RED;
    step(4);
    base = cyc;
    CAR_B = 1'b1;
    for (int k = 1; k <= 12; k++) expect_at(base + k, "glitch_ignored", M_SB | M_WB, 5'b00000);
    step(3);
    CAR_B = 1'b0;
    step(10);

    // Both streets green -> sticky FAULT until reset
    base = cyc;
    LB = L_GREEN;
    expect_at(base + 1, "fault_set", M_SA | M_SB | M_F, 5'b00001);
    step(2);
    base = cyc;
    LB = L_RED;
    expect_at(base + 1, "fault_sticky_1", M_F | M_SA | M_SB, 5'b00001);
    expect_at(base + 4, "fault_sticky_4", M_F, 5'b00001);
    step(5);
    base = cyc;
    RST = 1'b1;
    expect_at(base + 1, "fault_cleared_by_rst", M_ALL, 5'b00000);
    step(1);
    RST = 1'b0;
    step(2);

    // Reset mid-handover drops SB and the pending request
    base = cyc;
    PED_A = 1'b1;
    expect_at(base + 8, "pre_rst_sb", M_SB | M_WB, 5'b01010);
    step(9);
    RST = 1'b1;
    LA = L_RED;
    expect_at(base + 10, "rst_mid_handover", M_ALL, 5'b00000);
    step(1);
    RST = 1'b0;
    PED_A = 1'b0;
    step(8);

    // After reset the arbiter waits in SYNC: no SB until LA reads GREEN
    base = cyc;
    CAR_B = 1'b1;
    expect_at(base + 7, "sync_reqb_no_sb", M_WB | M_SB, 5'b00010);
    expect_at(base + 10, "sync_still_no_sb", M_SB, 5'b00000);
    step(10);
    base = cyc;
    LA = L_GREEN;
    expect_at(base + 1, "sync_to_pha_sb", M_ALL, 5'b01010);
    step(2);

`ifdef TL_ARB_EMERGENCY_EN
    // Emergency for phase B bypasses the extension
    CAR_B = 1'b0;
    LA = L_RED;
    LB = L_GREEN;
    step(10);
    LA = L_GREEN;
    LB = L_RED;
    CAR_A = 1'b1;
    step(10);
    base = cyc;
    EMG_B = 1'b1;
    expect_at(base + 3, "emg_sb_not_yet", M_SB, 5'b00000);
    expect_at(base + 4, "emg_sb_no_ext", M_SB | M_WB, 5'b01010);
    step(6);
    EMG_B = 1'b0;
`endif

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 200 && exp_fifo.size() != 0; k++) step(1);
    if (exp_fifo.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unsampled, want 0", exp_fifo.size());
    end
    step(1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
